bk_chain_adder: RTL and testbench
=================================

# bk_chain_adder

Multi-precision adder stage feeding the board's `uo_out` output mux.

- Collects two operands of `WIDTH*SLICES` bits over a narrow `WIDTH`-bit input bus, one slice per cycle.
- Adds them slice by slice through a single `WIDTH`-bit Brent-Kung slice adder, carrying between slices in a register.
- Streams the sum back out one slice per cycle.
- Extends the 6-bit combinational adder path to 24-bit operands within the pin budget of the tile.

## Interface
- `WIDTH`, 6, slice width in bits
- `SLICES`, 4, slices per operand (operand width = `WIDTH*SLICES`)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  `in_data` holds a slice to load this cycle
- `in_is_b`  in  1  0: slice goes to operand A, 1: slice goes to operand B
- `in_data`  in  `WIDTH`  operand slice, least significant slice first
- `start`  in  1  request an add of the loaded operands
- `cin`  in  1  carry into slice 0, sampled with `start`
- `busy`  out  1  add in progress
- `out_valid`  out  1  `out_data` holds a result slice
- `out_data`  out  `WIDTH`  sum slice, least significant first
- `out_last`  out  1  marks the final slice
- `cout`  out  1  carry out of the top slice, valid only with `out_last`
- `err`  out  1  sticky misuse flag

## Operation
**Storage and counters**
- Operands A and B are held in `WIDTH*SLICES` registers.
- Each has a load counter `a_cnt` / `b_cnt` (0..`SLICES`).
- A load writes slice index `cnt`, then increments `cnt`.

**States `IDLE`, `RUN`, `DONE`**
- `IDLE`
  - Loads are accepted.
  - `start` with `a_cnt==SLICES` and `b_cnt==SLICES`: latch `cin` into the carry register, clear slice index `k`, go to `RUN`.
  - `start` with either count short: ignored, `err` set.
- `RUN`
  - Each cycle computes `{c, s} = A[k] + B[k] + carry` and registers `s` to `out_data` and `c` to the carry register.
  - Asserts `out_valid`, then increments `k`.
  - At `k==SLICES-1`: assert `out_last`, drive `cout=c`, go to `DONE`.
- `DONE`
  - One cycle.
  - Clears `a_cnt`, `b_cnt` and `k`; operand contents are left stale.
  - Returns to `IDLE`.

**Boundary conditions**
- Load while `cnt==SLICES`: data dropped, `err` set.
- Load in `RUN` or `DONE`: dropped, `err` set.
- `start` in `RUN` or `DONE`: ignored, `err` unaffected.
- Same-cycle load and `start` in `IDLE`: the load is applied, and `start` is judged on the pre-load counts.
- `err` clears only on reset.

**Arithmetic**
- Unsigned, modulo `2^(WIDTH*SLICES)`.
- True carry out on `cout`.
- Per-slice sum is `WIDTH+1` bits; the MSB is the next carry.

## Timing
**Reset values** (asynchronous, `rst_n=0`)
- `busy=0`, `out_valid=0`, `out_data=0`, `out_last=0`, `cout=0`, `err=0`.
- State `IDLE`, all counters 0, carry 0, operand registers 0.

**Latency**
- `start` sampled at edge t gives the first `out_valid` after edge t+1.
- Slices appear on `SLICES` consecutive cycles with no gaps.
- `out_last` is on the last of them.

**`busy`**
- Registered.
- High from the edge after `start` is accepted through the `DONE` cycle.

**Back-to-back operation**
- The next load is accepted in the cycle after `DONE`.
- Minimum period for one add, excluding loads: `SLICES+2` cycles.

**Reset mid-`RUN`**
- Output stream is aborted immediately; no `out_last` is produced.
- Operands are lost.

**Other**
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `BK_CHAIN_SUB_EN` defined:
  - Adds input port `sub` (1 bit), sampled with `start`.
  - When `sub=1`, B slices are inverted into the adder and the initial carry is forced to 1, ignoring `cin`, giving A−B mod `2^(WIDTH*SLICES)`.
  - `cout=1` means no borrow.
- Undefined:
  - No `sub` port; add only.

## Structure
- Package `bk_chain_pkg`:
  - state enum `bk_state_t` (`IDLE`, `RUN`, `DONE`)
  - default constants `BK_WIDTH=6`, `BK_SLICES=4`
  - counter width function `$clog2(SLICES+1)`
- Sub-module `bk_slice_add`:
  - combinational `WIDTH`-bit Brent-Kung adder with carry in and carry out
  - one instance in the top

## Test plan
- Basic add:
  - Stimulus: A=0x000001 (slices 1,0,0,0), B=0x000002, cin=0.
  - Response: out_data 3,0,0,0; out_last on 4th; cout=0.
- Full carry ripple:
  - Stimulus: A=0xFFFFFF, B=0x000000, cin=1.
  - Response: out_data 0,0,0,0; cout=1; first out_valid exactly 1 cycle after the start edge.
- Incomplete operands:
  - Stimulus: `start` with only 3 B slices loaded.
  - Response: no out_valid, `err=1`; after the 4th B slice and a new `start`, a normal result.
- Misuse while running:
  - Stimulus: 5th A load, plus a load during `RUN`.
  - Response: `err=1`, result unchanged from the 4-slice operands.
- Reset mid-`RUN`:
  - Stimulus: drop `rst_n` after the 2nd output slice.
  - Response: all outputs 0 at once, `busy=0`, counters 0.
- With `BK_CHAIN_SUB_EN`:
  - Stimulus: A=0x000005, B=0x000007, sub=1.
  - Response: out_data 0x3E,0x3F,0x3F,0x3F (0xFFFFFE); cout=0.

Source files
------------

// File: rtl/bk_chain_pkg.sv
// Shared types and defaults for the multi-precision Brent-Kung chain adder.
package bk_chain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } bk_state_t;

  localparam int BK_WIDTH  = 6;
  localparam int BK_SLICES = 4;

  // Load counters must be able to hold the value SLICES itself ("operand full").
  function automatic int cnt_width(input int slices);
    return $clog2(slices + 1);
  endfunction

endpackage

// File: rtl/bk_chain_adder_if.sv
// Slice-serial load/start/result bus of bk_chain_adder.
// The optional sub port exists only when BK_CHAIN_SUB_EN is defined.
interface bk_chain_adder_if
  import bk_chain_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH
);
  logic             in_valid;
  logic             in_is_b;
  logic [WIDTH-1:0] in_data;
  logic             start;
  logic             cin;
`ifdef BK_CHAIN_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             cout;
  logic             err;

  modport master (
`ifdef BK_CHAIN_SUB_EN
    output sub,
`endif
    output in_valid, in_is_b, in_data, start, cin,
    input  busy, out_valid, out_data, out_last, cout, err
  );

  modport slave (
`ifdef BK_CHAIN_SUB_EN
    input  sub,
`endif
    input  in_valid, in_is_b, in_data, start, cin,
    output busy, out_valid, out_data, out_last, cout, err
  );

endinterface

// File: rtl/bk_slice_add.sv
// Combinational WIDTH-bit Brent-Kung adder with carry in and carry out.
module bk_slice_add
  import bk_chain_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LVLS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // cin is folded into bit 0's generate, so the prefix tree yields every carry directly.
  always_comb begin
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gp;
    logic [WIDTH-1:0] pp;
    logic [WIDTH:0]   c;
    int               d;
    int               src;
    p     = a ^ b;
    gp    = a & b;
    gp[0] = gp[0] | (p[0] & cin);
    pp    = p;
    for (int l = 0; l < LVLS; l++) begin
      d = 1 << l;
      for (int i = 0; i < WIDTH; i++) begin
        src = (i >= d) ? i - d : 0;
        if (((i + 1) % (2 * d)) == 0) begin
          gp[i] = gp[i] | (pp[i] & gp[src]);
          pp[i] = pp[i] & pp[src];
        end
      end
    end
    for (int l = LVLS - 1; l >= 0; l--) begin
      d = 1 << l;
      for (int i = 0; i < WIDTH; i++) begin
        src = (i >= d) ? i - d : 0;
        if ((((i + 1) % (2 * d)) == d) && ((i + 1) >= 3 * d)) begin
          gp[i] = gp[i] | (pp[i] & gp[src]);
        end
      end
    end
    c    = {gp, cin};
    sum  = p ^ c[WIDTH-1:0];
    cout = c[WIDTH];
  end

endmodule

// File: rtl/bk_chain_adder.sv
// Slice-serial multi-precision adder: loads A/B one slice per cycle, streams A+B out LSB first.
// Define BK_CHAIN_SUB_EN to add a sub input that computes A-B instead.
module bk_chain_adder
  import bk_chain_pkg::*;
#(
  parameter int WIDTH  = BK_WIDTH,
  parameter int SLICES = BK_SLICES
) (
  input logic               clk,
  input logic               rst_n,
  bk_chain_adder_if.slave   bus
);

  localparam int CW = cnt_width(SLICES);
  localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] FULL = CW'(SLICES);
  localparam logic [KW-1:0] LAST = KW'(SLICES - 1);

  bk_state_t        state, next_state;
  logic [WIDTH-1:0] a_reg [SLICES];
  logic [WIDTH-1:0] b_reg [SLICES];
  logic [CW-1:0]    a_cnt, b_cnt;
  logic [KW-1:0]    k;
  logic             carry;
  logic             busy_q, out_valid_q, out_last_q, cout_q, err_q;
  logic [WIDTH-1:0] out_data_q;
  logic             go, start_err, load_a, load_b, load_err;
  logic [WIDTH-1:0] b_op, slice_sum;
  logic             slice_cout;
`ifdef BK_CHAIN_SUB_EN
  logic             sub_r;
  assign b_op = b_reg[k] ^ {WIDTH{sub_r}};
`else
  assign b_op = b_reg[k];
`endif

  bk_slice_add #(.WIDTH(WIDTH)) u_slice_add (
    .a    (a_reg[k]),
    .b    (b_op),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // start is judged on the counts before any same-cycle load lands.
  always_comb begin
    next_state = state;
    go         = 1'b0;
    start_err  = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_err   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_is_b) begin
            if (b_cnt == FULL) load_err = 1'b1;
            else               load_b   = 1'b1;
          end else begin
            if (a_cnt == FULL) load_err = 1'b1;
            else               load_a   = 1'b1;
          end
        end
        if (bus.start) begin
          if ((a_cnt == FULL) && (b_cnt == FULL)) begin
            go         = 1'b1;
            next_state = RUN;
          end else begin
            start_err = 1'b1;
          end
        end
      end
      RUN: begin
        load_err = bus.in_valid;
        if (k == LAST) next_state = DONE;
      end
      DONE: begin
        load_err   = bus.in_valid;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SLICES; s++) begin
        a_reg[s] <= '0;
        b_reg[s] <= '0;
      end
      a_cnt       <= '0;
      b_cnt       <= '0;
      k           <= '0;
      carry       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef BK_CHAIN_SUB_EN
      sub_r       <= 1'b0;
`endif
    end else begin
      if (load_a) begin
        a_reg[a_cnt[KW-1:0]] <= bus.in_data;
        a_cnt                <= a_cnt + 1'b1;
      end
      if (load_b) begin
        b_reg[b_cnt[KW-1:0]] <= bus.in_data;
        b_cnt                <= b_cnt + 1'b1;
      end
      if (load_err || start_err) err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (go) begin
            k      <= '0;
            busy_q <= 1'b1;
`ifdef BK_CHAIN_SUB_EN
            sub_r  <= bus.sub;
            carry  <= bus.sub | bus.cin;
`else
            carry  <= bus.cin;
`endif
          end
        end
        RUN: begin
          out_valid_q <= 1'b1;
          out_data_q  <= slice_sum;
          carry       <= slice_cout;
          k           <= k + 1'b1;
          out_last_q  <= (k == LAST);
          cout_q      <= (k == LAST) & slice_cout;
        end
        DONE: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          cout_q      <= 1'b0;
          busy_q      <= 1'b0;
          a_cnt       <= '0;
          b_cnt       <= '0;
          k           <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.cout      = cout_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bk_chain_adder.sv
// Scoreboard bench for bk_chain_adder: whole-operand arithmetic model, monitor checks each slice.
module tb_bk_chain_adder;
  import bk_chain_pkg::*;

  localparam int W   = BK_WIDTH;
  localparam int S   = BK_SLICES;
  localparam int OPW = W * S;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic         cout;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  bk_chain_adder_if #(.WIDTH(W)) bus ();

  bk_chain_adder #(.WIDTH(W), .SLICES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-width arithmetic, then cut into slices.
  task automatic push_expected(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                               input logic cin, input logic sub);
    logic [OPW:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (OPW+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + (OPW+1)'(cin);
    for (int s = 0; s < S; s++) begin
      exp_t e;
      e.data = r[s*W +: W];
      e.last = (s == S - 1);
      e.cout = r[OPW];
      sb.push_back(e);
    end
  endtask

  task automatic load_slices(input logic is_b, input logic [OPW-1:0] v, input int first, input int n);
    for (int s = first; s < first + n; s++) begin
      bus.in_valid = 1'b1;
      bus.in_is_b  = is_b;
      bus.in_data  = v[s*W +: W];
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                          input logic cin, input logic sub, input logic expect_ok);
    if (expect_ok) push_expected(a, b, cin, sub);
    bus.start = 1'b1;
    bus.cin   = cin;
`ifdef BK_CHAIN_SUB_EN
    bus.sub   = sub;
`endif
    tick();
    bus.start = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                input logic cin, input logic sub);
    load_slices(1'b0, a, 0, S);
    load_slices(1'b1, b, 0, S);
    do_start(a, b, cin, sub, 1'b1);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((bus.busy || sb.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    check_output("drain_timeout", 32'(n < 40), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    tick();
  endtask

  // Monitor: every presented slice must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        check_output("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("slice_data", 32'(bus.out_data), 32'(e.data));
        check_output("slice_last", 32'(bus.out_last), 32'(e.last));
        if (e.last) check_output("cout", 32'(bus.cout), 32'(e.cout));
      end
    end
  end

  initial begin
    logic [OPW-1:0] a, b;
    logic           cin, sub_sel;
    bus.in_valid = 1'b0;
    bus.in_is_b  = 1'b0;
    bus.in_data  = '0;
    bus.start    = 1'b0;
    bus.cin      = 1'b0;
`ifdef BK_CHAIN_SUB_EN
    bus.sub      = 1'b0;
`endif
    tick();
    tick();
    check_output("rst_busy",      32'(bus.busy),      32'd0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_data",  32'(bus.out_data),  32'd0);
    check_output("rst_out_last",  32'(bus.out_last),  32'd0);
    check_output("rst_cout",      32'(bus.cout),      32'd0);
    check_output("rst_err",       32'(bus.err),       32'd0);
    rst_n = 1'b1;
    tick();

    apply_stimulus(24'h000001, 24'h000002, 1'b0, 1'b0);
    wait_done();
    check_output("basic_err", 32'(bus.err), 32'd0);

    // Full ripple, with exact latency and gap-free streaming.
    load_slices(1'b0, 24'hFFFFFF, 0, S);
    load_slices(1'b1, 24'h000000, 0, S);
    do_start(24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 1'b1);
    check_output("lat_busy",  32'(bus.busy),      32'd1);
    check_output("lat_valid", 32'(bus.out_valid), 32'd0);
    for (int j = 0; j < S; j++) begin
      tick();
      check_output("stream_valid", 32'(bus.out_valid), 32'd1);
    end
    tick();
    check_output("done_valid", 32'(bus.out_valid), 32'd0);
    check_output("done_busy",  32'(bus.busy),      32'd0);
    wait_done();

    // Short B, then the 4th B slice arrives together with start: start still rejected.
    a = 24'h123456;
    b = 24'hABCDEF;
    load_slices(1'b0, a, 0, S);
    load_slices(1'b1, b, 0, S - 1);
    bus.in_valid = 1'b1;
    bus.in_is_b  = 1'b1;
    bus.in_data  = b[(S-1)*W +: W];
    do_start(a, b, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    check_output("short_err",  32'(bus.err),  32'd1);
    check_output("short_busy", 32'(bus.busy), 32'd0);
    do_start(a, b, 1'b0, 1'b0, 1'b1);
    wait_done();

    // start during RUN is ignored and leaves err clear.
    do_reset();
    check_output("reset_err_clear", 32'(bus.err), 32'd0);
    apply_stimulus(24'h0F0F0F, 24'h00FF00, 1'b1, 1'b0);
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done();
    check_output("run_start_err", 32'(bus.err), 32'd0);

    // 5th A slice dropped; result uses the first four.
    a = 24'h3C2A15;
    b = 24'h01F0E1;
    load_slices(1'b0, a, 0, S);
    check_output("pre_overflow_err", 32'(bus.err), 32'd0);
    load_slices(1'b0, 24'hFFFFFF, 0, 1);
    check_output("overflow_err", 32'(bus.err), 32'd1);
    load_slices(1'b1, b, 0, S);
    do_start(a, b, 1'b0, 1'b0, 1'b1);
    wait_done();

    // A load during RUN alone sets err and does not disturb the stream.
    do_reset();
    apply_stimulus(24'hFEDCBA, 24'h012345, 1'b1, 1'b0);
    tick();
    load_slices(1'b0, 24'h2AAAAA, 0, 1);
    wait_done();
    check_output("run_load_err", 32'(bus.err), 32'd1);

    // Reset while the 2nd slice is on the bus.
    do_reset();
    apply_stimulus(24'h777777, 24'h111111, 1'b0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_valid", 32'(bus.out_valid), 32'd0);
    check_output("midrst_data",  32'(bus.out_data),  32'd0);
    check_output("midrst_last",  32'(bus.out_last),  32'd0);
    check_output("midrst_busy",  32'(bus.busy),      32'd0);
    check_output("midrst_cout",  32'(bus.cout),      32'd0);
    sb.delete();
    #2;
    rst_n = 1'b1;
    tick();
    check_output("midrst_err", 32'(bus.err), 32'd0);
    apply_stimulus(24'h00ABCD, 24'hF00001, 1'b0, 1'b0);
    wait_done();
    check_output("post_rst_err", 32'(bus.err), 32'd0);

`ifdef BK_CHAIN_SUB_EN
    apply_stimulus(24'h000005, 24'h000007, 1'b0, 1'b1);
    wait_done();
`endif

    for (int n = 0; n < 16; n++) begin
      a       = OPW'($urandom);
      b       = OPW'($urandom);
      cin     = 1'($urandom_range(0, 1));
      sub_sel = 1'b0;
`ifdef BK_CHAIN_SUB_EN
      sub_sel = 1'($urandom_range(0, 1));
`endif
      if (n == 3) begin
        a = '1;
        b = '1;
      end
      apply_stimulus(a, b, cin, sub_sel);
      wait_done();
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
